// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_e;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

  // Parity bit from the XOR-reduction of the payload (1 = odd number of ones).
  function automatic logic parity_bit(input parity_e mode, input logic ones_odd);
    return (mode == ODD) ? ~ones_odd : ones_odd;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Producer-side bus and line outputs of the buffered UART transmitter.
interface uart_tx_buffered_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) ();

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS:0] wr_opt_byte;
  logic               wr_ready;
  logic               tx_line;
  logic               busy;
  logic [CW-1:0]      fifo_count;
  logic               err_drop;

  modport master (
    output wr_opt_byte,
    input  wr_ready, tx_line, busy, fifo_count, err_drop
  );

  modport slave (
    input  wr_opt_byte,
    output wr_ready, tx_line, busy, fifo_count, err_drop
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count and registered full/empty flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // A push into a full FIFO is refused even if a pop happens in the same cycle.
  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  // Occupancy update.
  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally at the power-of-two depth; count keeps an extra bit.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO in front of a start/data/parity/stop serialiser.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = 8,
  parameter parity_e     PARITY       = NONE,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input logic               CLK,
  input logic               RST_N,
  uart_tx_buffered_if.slave bus
);

  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q;
  logic                 line_c;
  logic                 pop_c;

  logic                 wr_valid;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic [CW-1:0]        fifo_count;

  assign wr_valid = bus.wr_opt_byte[DATA_BITS];

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .push_i  (wr_valid & ~fifo_full & RST_N),
    .pop_i   (pop_c),
    .wdata_i (bus.wr_opt_byte[DATA_BITS-1:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state, bit timing, shifter and line level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop_c   = 1'b0;
    line_c  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_rdata;
          par_d   = parity_bit(PARITY, ^fifo_rdata);
          cnt_d   = BIT_LAST;
          state_d = START;
        end
      end
      START: begin
        line_c = 1'b0;
        if (cnt_q == '0) begin
          cnt_d   = BIT_LAST;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        line_c = shift_q[0];
        if (cnt_q == '0) begin
          if (idx_q == DATA_LAST) begin
            if (PARITY != NONE) begin
              cnt_d   = BIT_LAST;
              state_d = PAR;
            end else begin
              cnt_d   = STOP_LAST;
              state_d = STOP;
            end
          end else begin
            cnt_d   = BIT_LAST;
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PAR: begin
        line_c = par_q;
        if (cnt_q == '0) begin
          cnt_d   = STOP_LAST;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        line_c = 1'b1;
        if (cnt_q == '0) begin
          // Back-to-back frames: pop straight into the next start bit.
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = fifo_rdata;
            par_d   = parity_bit(PARITY, ^fifo_rdata);
            cnt_d   = BIT_LAST;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; the line level is registered so it is glitch-free.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= line_c;
    end
  end

  assign bus.wr_ready   = ~fifo_full & RST_N;
  assign bus.err_drop   = wr_valid & fifo_full & RST_N;
  assign bus.tx_line    = tx_q;
  assign bus.busy       = (state_q != IDLE) | ~fifo_empty;
  assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered across several parameter sets.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rst_v;
  logic [8:0] wr_b [5];
  logic [4:0] line_v, busy_v, rdy_v, drop_v;
  logic [4:0] cnt_v [5];

  int total = 0;
  int bad   = 0;

  bit         samp[$];
  bit         busy_s[$];
  logic [7:0] rx_bytes[$];
  int         rx_starts[$];
  int         rx_ferr;

  // 0: 8N1 depth 4 | 1: 8E1 | 2: 8O1 | 3: 7N2 | 4: 8N1 at 2 clocks per bit
  uart_tx_buffered_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if0 ();
  uart_tx_buffered_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if1 ();
  uart_tx_buffered_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if2 ();
  uart_tx_buffered_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) if3 ();
  uart_tx_buffered_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if4 ();

  uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(NONE), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut0 (.CLK(clk), .RST_N(rst_v[0]), .bus(if0.slave));
  uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(EVEN), .STOP_BITS(1), .FIFO_DEPTH(16))
    dut1 (.CLK(clk), .RST_N(rst_v[1]), .bus(if1.slave));
  uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(ODD), .STOP_BITS(1), .FIFO_DEPTH(16))
    dut2 (.CLK(clk), .RST_N(rst_v[2]), .bus(if2.slave));
  uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(NONE), .STOP_BITS(2), .FIFO_DEPTH(16))
    dut3 (.CLK(clk), .RST_N(rst_v[3]), .bus(if3.slave));
  uart_tx_buffered #(.CLKS_PER_BIT(2), .DATA_BITS(8), .PARITY(NONE), .STOP_BITS(1), .FIFO_DEPTH(16))
    dut4 (.CLK(clk), .RST_N(rst_v[4]), .bus(if4.slave));

  assign if0.wr_opt_byte = wr_b[0];
  assign if1.wr_opt_byte = wr_b[1];
  assign if2.wr_opt_byte = wr_b[2];
  assign if3.wr_opt_byte = {wr_b[3][8], wr_b[3][6:0]};
  assign if4.wr_opt_byte = wr_b[4];

  assign line_v = {if4.tx_line, if3.tx_line, if2.tx_line, if1.tx_line, if0.tx_line};
  assign busy_v = {if4.busy, if3.busy, if2.busy, if1.busy, if0.busy};
  assign rdy_v  = {if4.wr_ready, if3.wr_ready, if2.wr_ready, if1.wr_ready, if0.wr_ready};
  assign drop_v = {if4.err_drop, if3.err_drop, if2.err_drop, if1.err_drop, if0.err_drop};
  assign cnt_v[0] = 5'(if0.fifo_count);
  assign cnt_v[1] = 5'(if1.fifo_count);
  assign cnt_v[2] = 5'(if2.fifo_count);
  assign cnt_v[3] = 5'(if3.fifo_count);
  assign cnt_v[4] = 5'(if4.fifo_count);

  // Ideal line level during bit period p of a frame (par: 0 none, 1 odd, 2 even).
  function automatic bit exp_bit(input int p, input logic [7:0] data, input int dbits, input int par);
    logic [7:0] m;
    m = data & 8'((1 << dbits) - 1);
    if (p == 0) return 1'b0;
    if (p <= dbits) return m[p-1];
    if (par != 0 && p == dbits + 1) return (par == 2) ? (^m) : ~(^m);
    return 1'b1;
  endfunction

  // Reference receiver over recorded line samples (no parity): mid-bit sampling.
  task automatic decode(input int cpb, input int dbits, input int nstop);
    int i;
    int flen;
    logic [7:0] b;
    flen = (1 + dbits + nstop) * cpb;
    rx_bytes.delete();
    rx_starts.delete();
    rx_ferr = 0;
    i = 0;
    while (i < samp.size()) begin
      if (samp[i] == 1'b0) begin
        if (i + flen > samp.size()) begin
          rx_ferr++;
          break;
        end
        b = '0;
        for (int k = 0; k < dbits; k++) b[k] = samp[i + cpb * (1 + k) + cpb / 2];
        for (int s = 0; s < nstop; s++)
          if (samp[i + cpb * (1 + dbits + s) + cpb / 2] != 1'b1) rx_ferr++;
        rx_bytes.push_back(b);
        rx_starts.push_back(i);
        i += flen;
      end else begin
        i++;
      end
    end
  endtask

  task automatic reset_dut(input int d);
    @(negedge clk);
    rst_v[d] = 1'b0;
    wr_b[d]  = '0;
    @(negedge clk);
    @(negedge clk);
    rst_v[d] = 1'b1;
  endtask

  task automatic test_reset();
    rst_v = '0;
    for (int d = 0; d < 5; d++) wr_b[d] = {1'b1, 8'($urandom)};
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 5; d++) begin
      total++; if (line_v[d] !== 1'b1) begin bad++; $display("FAIL reset_line d%0d got %b want 1", d, line_v[d]); end
      total++; if (busy_v[d] !== 1'b0) begin bad++; $display("FAIL reset_busy d%0d got %b want 0", d, busy_v[d]); end
      total++; if (cnt_v[d] !== 5'd0) begin bad++; $display("FAIL reset_count d%0d got %0d want 0", d, cnt_v[d]); end
      total++; if (rdy_v[d] !== 1'b0) begin bad++; $display("FAIL reset_ready d%0d got %b want 0", d, rdy_v[d]); end
      total++; if (drop_v[d] !== 1'b0) begin bad++; $display("FAIL reset_drop d%0d got %b want 0", d, drop_v[d]); end
    end
    for (int d = 0; d < 5; d++) wr_b[d] = '0;
    wr_b[0] = {1'b1, 8'h3C};
    rst_v = '1;
    #1;
    total++; if (rdy_v[0] !== 1'b1) begin bad++; $display("FAIL release_ready got %b want 1", rdy_v[0]); end
    @(negedge clk);
    wr_b[0] = '0;
    total++; if (cnt_v[0] !== 5'd1) begin bad++; $display("FAIL release_accept got %0d want 1", cnt_v[0]); end
    reset_dut(0);
  endtask

  // One byte into an idle DUT, checked cycle by cycle (4 clocks per bit).
  task automatic send_check(input int d, input logic [7:0] data, input int dbits,
                            input int par, input int nstop, input string nm);
    int flen;
    bit e;
    flen = (1 + dbits + ((par != 0) ? 1 : 0) + nstop) * 4;
    wr_b[d] = {1'b1, data};
    #1;
    total++; if (rdy_v[d] !== 1'b1) begin bad++; $display("FAIL %s ready got %b want 1", nm, rdy_v[d]); end
    @(negedge clk);
    wr_b[d] = '0;
    @(negedge clk);
    total++; if (line_v[d] !== 1'b1) begin bad++; $display("FAIL %s early_start got %b want 1", nm, line_v[d]); end
    total++; if (busy_v[d] !== 1'b1) begin bad++; $display("FAIL %s busy got %b want 1", nm, busy_v[d]); end
    for (int i = 0; i < flen; i++) begin
      @(negedge clk);
      e = exp_bit(i / 4, data, dbits, par);
      total++;
      if (line_v[d] !== e) begin
        bad++; $display("FAIL %s line cycle %0d got %b want %b", nm, i, line_v[d], e);
      end
      if (i == flen - 2) begin
        total++; if (busy_v[d] !== 1'b1) begin bad++; $display("FAIL %s busy_tail got %b want 1", nm, busy_v[d]); end
      end
      if (i == flen - 1) begin
        total++; if (busy_v[d] !== 1'b0) begin bad++; $display("FAIL %s busy_end got %b want 0", nm, busy_v[d]); end
      end
    end
    @(negedge clk);
    total++; if (line_v[d] !== 1'b1) begin bad++; $display("FAIL %s idle_after got %b want 1", nm, line_v[d]); end
  endtask

  task automatic test_frames();
    send_check(0, 8'h55, 8, 0, 1, "8n1_55");
    send_check(1, 8'h07, 8, 2, 1, "8e1_07");
    send_check(2, 8'h07, 8, 1, 1, "8o1_07");
    send_check(3, 8'h41, 7, 0, 2, "7n2_41");
    for (int r = 0; r < 2; r++) begin
      send_check(0, 8'($urandom), 8, 0, 1, "8n1_rand");
      send_check(1, 8'($urandom), 8, 2, 1, "8e1_rand");
      send_check(2, 8'($urandom), 8, 1, 1, "8o1_rand");
      send_check(3, 8'($urandom), 7, 0, 2, "7n2_rand");
    end
  endtask

  // Six back-to-back writes into an idle depth-4 buffer.
  task automatic test_overflow();
    logic [7:0] b [6];
    reset_dut(0);
    samp.delete();
    busy_s.delete();
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    for (int j = 0; j < 260; j++) begin
      wr_b[0] = (j < 6) ? {1'b1, b[j]} : 9'h0;
      #1;
      if (j < 6) begin
        total++; if (rdy_v[0] !== 1'(j < 5)) begin bad++; $display("FAIL ovf_ready w%0d got %b want %b", j, rdy_v[0], j < 5); end
        total++; if (drop_v[0] !== 1'(j == 5)) begin bad++; $display("FAIL ovf_drop w%0d got %b want %b", j, drop_v[0], j == 5); end
      end
      @(negedge clk);
      samp.push_back(line_v[0]);
      busy_s.push_back(busy_v[0]);
      if (j == 1) begin
        total++; if (cnt_v[0] !== 5'd1) begin bad++; $display("FAIL ovf_pushpop_count got %0d want 1", cnt_v[0]); end
      end
      if (j == 4) begin
        total++; if (cnt_v[0] !== 5'd4) begin bad++; $display("FAIL ovf_full_count got %0d want 4", cnt_v[0]); end
      end
    end
    decode(4, 8, 1);
    total++; if (rx_bytes.size() != 5) begin bad++; $display("FAIL ovf_frames got %0d want 5", rx_bytes.size()); end
    for (int k = 0; k < 5 && k < rx_bytes.size(); k++) begin
      total++; if (rx_bytes[k] !== b[k]) begin bad++; $display("FAIL ovf_byte %0d got %h want %h", k, rx_bytes[k], b[k]); end
      total++; if (rx_starts[k] != 2 + 40 * k) begin bad++; $display("FAIL ovf_gap %0d got %0d want %0d", k, rx_starts[k], 2 + 40 * k); end
    end
    total++; if (rx_ferr != 0) begin bad++; $display("FAIL ovf_stop got %0d want 0", rx_ferr); end
    total++; if (busy_s[200] !== 1'b1) begin bad++; $display("FAIL ovf_busy_last got %b want 1", busy_s[200]); end
    total++; if (busy_s[201] !== 1'b0) begin bad++; $display("FAIL ovf_busy_fall got %b want 0", busy_s[201]); end
  endtask

  // Write attempted while full in the same cycle the serialiser pops.
  task automatic test_full_pop();
    reset_dut(0);
    for (int j = 0; j <= 41; j++) begin
      wr_b[0] = (j < 5 || j == 41) ? {1'b1, 8'($urandom)} : 9'h0;
      #1;
      if (j == 41) begin
        total++; if (rdy_v[0] !== 1'b0) begin bad++; $display("FAIL fullpop_ready got %b want 0", rdy_v[0]); end
        total++; if (drop_v[0] !== 1'b1) begin bad++; $display("FAIL fullpop_drop got %b want 1", drop_v[0]); end
        total++; if (cnt_v[0] !== 5'd4) begin bad++; $display("FAIL fullpop_pre got %0d want 4", cnt_v[0]); end
      end
      @(negedge clk);
    end
    wr_b[0] = '0;
    total++; if (cnt_v[0] !== 5'd3) begin bad++; $display("FAIL fullpop_post got %0d want 3", cnt_v[0]); end
    total++; if (drop_v[0] !== 1'b0) begin bad++; $display("FAIL fullpop_pulse got %b want 0", drop_v[0]); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b [4];
    int lows;
    int busies;
    reset_dut(0);
    for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
    for (int j = 0; j <= 18; j++) begin
      wr_b[0] = (j < 4) ? {1'b1, b[j]} : 9'h0;
      @(negedge clk);
      if (j == 3) begin
        total++; if (cnt_v[0] !== 5'd3) begin bad++; $display("FAIL mid_queued got %0d want 3", cnt_v[0]); end
      end
    end
    total++; if (line_v[0] !== b[0][3]) begin bad++; $display("FAIL mid_bit3 got %b want %b", line_v[0], b[0][3]); end
    rst_v[0] = 1'b0;
    @(negedge clk);
    total++; if (line_v[0] !== 1'b1) begin bad++; $display("FAIL mid_line got %b want 1", line_v[0]); end
    total++; if (cnt_v[0] !== 5'd0) begin bad++; $display("FAIL mid_count got %0d want 0", cnt_v[0]); end
    total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL mid_busy got %b want 0", busy_v[0]); end
    rst_v[0] = 1'b1;
    lows = 0;
    busies = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (line_v[0] !== 1'b1) lows++;
      if (busy_v[0] !== 1'b0) busies++;
    end
    total++; if (lows != 0) begin bad++; $display("FAIL mid_silent got %0d want 0", lows); end
    total++; if (busies != 0) begin bad++; $display("FAIL mid_idle got %0d want 0", busies); end
  endtask

  // 64 random bytes at maximum rate, decoded by the reference receiver.
  task automatic test_stream();
    logic [7:0] q [64];
    int sent;
    int drops;
    int cyc;
    bit go;
    reset_dut(4);
    samp.delete();
    for (int k = 0; k < 64; k++) q[k] = 8'($urandom);
    sent = 0;
    drops = 0;
    cyc = 0;
    while (sent < 64 && cyc < 3000) begin
      go = (rdy_v[4] === 1'b1);
      wr_b[4] = go ? {1'b1, q[sent]} : 9'h0;
      #1;
      if (drop_v[4] === 1'b1) drops++;
      @(negedge clk);
      samp.push_back(line_v[4]);
      if (go) sent++;
      cyc++;
    end
    wr_b[4] = '0;
    total++; if (sent != 64) begin bad++; $display("FAIL stream_accept got %0d want 64", sent); end
    cyc = 0;
    while (busy_v[4] !== 1'b0 && cyc < 3000) begin
      @(negedge clk);
      samp.push_back(line_v[4]);
      cyc++;
    end
    total++; if (busy_v[4] !== 1'b0) begin bad++; $display("FAIL stream_drain got %b want 0", busy_v[4]); end
    repeat (4) begin
      @(negedge clk);
      samp.push_back(line_v[4]);
    end
    decode(2, 8, 1);
    total++; if (rx_bytes.size() != 64) begin bad++; $display("FAIL stream_frames got %0d want 64", rx_bytes.size()); end
    for (int k = 0; k < 64 && k < rx_bytes.size(); k++) begin
      total++; if (rx_bytes[k] !== q[k]) begin bad++; $display("FAIL stream_byte %0d got %h want %h", k, rx_bytes[k], q[k]); end
    end
    total++; if (drops != 0) begin bad++; $display("FAIL stream_drops got %0d want 0", drops); end
    total++; if (rx_ferr != 0) begin bad++; $display("FAIL stream_stop got %0d want 0", rx_ferr); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_overflow();
    test_full_pop();
    test_reset_midframe();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d checks", total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 The block SHALL have exactly one clock, CLK, and one reset, RST_N; RST_N is synchronous and active-low.
REQ-002 The block SHALL expose these parameters:
- CLKS_PER_BIT, default 868: CLK cycles per UART bit; legal range 2..65535.
- DATA_BITS, default 8: data bits per frame; legal range 5..8.
- PARITY, default NONE: one of NONE, ODD or EVEN.
- STOP_BITS, default 1: number of stop bits, 1 or 2.
- FIFO_DEPTH, default 16: transmit buffer entries; must be a power of two, at least 2.
REQ-003 The block SHALL expose these ports:
- CLK, in, 1: clock.
- RST_N, in, 1: synchronous active-low reset.
- wr_opt_byte, in, DATA_BITS+1: MSB is the valid flag; the low DATA_BITS bits are the payload.
- wr_ready, out, 1: the buffer can accept a byte this cycle.
- tx_line, out, 1: serial output; idle level is 1.
- busy, out, 1: a frame is on the line or the FIFO is non-empty.
- fifo_count, out, clog2(FIFO_DEPTH)+1: number of occupied entries.
- err_drop, out, 1: one-cycle pulse when a valid byte is refused.

Function
REQ-004 A byte SHALL be accepted on any rising edge where valid=1 and wr_ready=1.
REQ-005 wr_ready SHALL equal (fifo_count != FIFO_DEPTH) AND RST_N.
- A pop in the same cycle SHALL NOT free a slot for a write while the FIFO is full.
REQ-006 When valid=1 and wr_ready=0, err_drop SHALL be 1 for that cycle and the byte SHALL be discarded.
- RST_N low SHALL suppress err_drop.
REQ-007 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave fifo_count unchanged.
REQ-008 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and an extra count bit SHALL distinguish full from empty.
REQ-009 The transmit FSM SHALL have the states IDLE, START, DATA, PAR and STOP.
REQ-010 IDLE: tx_line=1; if the FIFO is non-empty, the FSM SHALL pop the head into the shift register and enter START on the next edge.
REQ-011 Each of START, DATA and PAR SHALL hold its bit for exactly CLKS_PER_BIT cycles, timed by a bit counter counting down from CLKS_PER_BIT-1 to 0.
REQ-012 START SHALL drive 0.
REQ-013 DATA SHALL send DATA_BITS bits LSB first, then go to PAR if PARITY != NONE, otherwise to STOP.
REQ-014 PAR SHALL drive the parity bit so that data plus parity has an odd (ODD) or even (EVEN) number of ones.
REQ-015 STOP SHALL drive 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-016 In the last STOP cycle, if the FIFO is non-empty, the FSM SHALL pop and enter START directly with zero idle gap; otherwise it SHALL return to IDLE.
REQ-017 Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE SHALL make tx_line fall to 0 at edge N+2.
REQ-018 Frame length SHALL be exactly (1 + DATA_BITS + (PARITY!=NONE) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-019 Payload bits above DATA_BITS are non-existent; the valid flag SHALL always be bit DATA_BITS.
REQ-020 busy SHALL be 1 whenever the FSM is not in IDLE or fifo_count != 0.

Reset
REQ-021 While RST_N=0 at an edge, the block SHALL set:
- FSM to IDLE, bit counter and bit index to 0, FIFO pointers and fifo_count to 0;
- tx_line=1, busy=0, err_drop=0.
REQ-022 A reset mid-frame SHALL truncate the frame, return tx_line to 1 at that edge, and discard all FIFO contents.
REQ-023 The first edge after RST_N rises SHALL accept a valid byte.

Structure
REQ-024 A shared package uart_pkg SHALL hold:
- the parity enum (NONE, ODD, EVEN);
- the FSM state enum;
- the default CLKS_PER_BIT constant.
REQ-025 The buffer SHALL be a separate sub-module, sync_fifo, parametrised by width and depth, with registered count and no combinational full-to-write path.
REQ-026 The FSM, bit counter and shift register SHALL live in uart_tx_buffered.

Verification
All scenarios use CLKS_PER_BIT=4 unless stated.
REQ-027 8N1, send 0x55 -> tx_line is low at edge N+2, then 1,0,1,0,1,0,1,0 with each bit 4 cycles, then stop high; total frame 40 cycles.
REQ-028 8E1, send 0x07 -> parity bit 1; 8O1, send 0x07 -> parity bit 0; 7N2, send 0x41 -> 7 data bits, stop high for 8 cycles.
REQ-029 FIFO_DEPTH=4, push 6 bytes back-to-back while idle -> the first 5 are accepted (one pops immediately), the 6th raises err_drop; all frames are contiguous with no idle gap; busy falls after the last stop bit.
REQ-030 Full FIFO with a pop in the same cycle as a valid write -> wr_ready=0, err_drop=1, fifo_count drops by 1.
REQ-031 Assert RST_N=0 during DATA bit 3 with 3 bytes queued -> next edge tx_line=1, fifo_count=0, busy=0; no further frames are sent.
REQ-032 CLKS_PER_BIT=2, 64 random bytes streamed at max rate -> a reference receiver decodes an identical sequence, with no err_drop while the producer honours wr_ready.
